sort_batch_ctrl: RTL and testbench

SORT_BATCH_CTRL -- requirements
Module: sort_batch_ctrl

---
 rtl/sort_pkg.sv | 12 +
 rtl/sort_drain_cnt.sv | 48 ++++
 rtl/sort_batch_ctrl.sv | 146 ++++++++++++++
 tb/tb_sort_batch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared state type and default sizing for the sort batch controller
package sort_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam int SORT_N     = 22;
   localparam int SORT_WIDTH = 8;
endpackage

// File: rtl/sort_drain_cnt.sv
// rtl/sort_drain_cnt.sv - receive/drain counters, end-of-batch and drain timeout detection
module sort_drain_cnt
   import sort_pkg::*;
#(
   parameter int N         = SORT_N,
   parameter int DRAIN_MAX = 2 * N,
   parameter int CW        = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          in_drain,
   input  logic          rvalid,
   input  logic [CW-1:0] load_cnt,
   output logic          item_ok,
   output logic          item_last,
   output logic          drain_tmo,
   output logic          timeout
);
   localparam int            DW    = $clog2(DRAIN_MAX + 1);
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [DW-1:0] DONE  = DW'(1);
   localparam logic [DW-1:0] DLAST = DW'(DRAIN_MAX - 1);

   logic [CW-1:0] rcv_cnt;
   logic [DW-1:0] drain_cnt;

   // Results past the loaded count are dropped; a real last item beats a same-cycle timeout.
   assign item_ok   = in_drain && rvalid && (rcv_cnt < load_cnt);
   assign item_last = item_ok && ((rcv_cnt + ONE) == load_cnt);
   assign drain_tmo = in_drain && !item_last && (drain_cnt == DLAST);

   always_ff @(posedge clk) begin
      if (!nreset) begin
         rcv_cnt   <= '0;
         drain_cnt <= '0;
         timeout   <= 1'b0;
      end else if (!in_drain) begin
         rcv_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         drain_cnt <= drain_cnt + DONE;
         if (item_ok)
            rcv_cnt <= rcv_cnt + ONE;
         if (drain_tmo)
            timeout <= 1'b1;
      end
   end
endmodule

// File: rtl/sort_batch_ctrl.sv
// rtl/sort_batch_ctrl.sv - batches items into a sorter, flushes and forwards sorted results
// Optional descending-order checker (order_err) under SORT_BATCH_ORDER_CHECK_EN.
module sort_batch_ctrl
   import sort_pkg::*;
#(
   parameter int N         = SORT_N,
   parameter int WIDTH     = SORT_WIDTH,
   parameter int DRAIN_MAX = 2 * N
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] srt_data,
   output logic             srt_valid,
   output logic             srt_flush,
   input  logic [WIDTH-1:0] srt_rdata,
   input  logic             srt_rvalid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy,
`ifdef SORT_BATCH_ORDER_CHECK_EN
   output logic             order_err,
`endif
   output logic             timeout
);
   localparam int            CW   = $clog2(N + 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] FULL = CW'(N);

   state_t        state;
   logic [CW-1:0] load_cnt;
   logic          accept;
   logic          in_drain;
   logic          item_ok;
   logic          item_last;
   logic          drain_tmo;

   assign accept   = in_valid && in_ready;
   assign in_drain = (state == DRAIN);

   sort_drain_cnt #(
      .N         (N),
      .DRAIN_MAX (DRAIN_MAX),
      .CW        (CW)
   ) u_drain_cnt (
      .clk       (clk),
      .nreset    (nreset),
      .in_drain  (in_drain),
      .rvalid    (srt_rvalid),
      .load_cnt  (load_cnt),
      .item_ok   (item_ok),
      .item_last (item_last),
      .drain_tmo (drain_tmo),
      .timeout   (timeout)
   );

   // in_ready, srt_flush and busy are registered alongside the state so they track it exactly.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state     <= IDLE;
         load_cnt  <= '0;
         in_ready  <= 1'b0;
         srt_flush <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE, FILL: begin
               if (accept) begin
                  load_cnt <= load_cnt + ONE;
                  busy     <= 1'b1;
                  if (((load_cnt + ONE) == FULL) || in_last) begin
                     state     <= DRAIN;
                     in_ready  <= 1'b0;
                     srt_flush <= 1'b1;
                  end else begin
                     state    <= FILL;
                     in_ready <= 1'b1;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            DRAIN: begin
               if (item_last || drain_tmo) begin
                  state     <= GAP;
                  srt_flush <= 1'b0;
               end
            end
            GAP: begin
               state    <= IDLE;
               load_cnt <= '0;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               load_cnt <= '0;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         srt_data  <= '0;
         srt_valid <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         srt_valid <= accept;
         if (accept)
            srt_data <= in_data;
         out_valid <= item_ok;
         out_last  <= item_last;
         if (item_ok)
            out_data <= srt_rdata;
      end
   end

`ifdef SORT_BATCH_ORDER_CHECK_EN
   logic [WIDTH-1:0] prev_item;
   logic             have_prev;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         order_err <= 1'b0;
         prev_item <= '0;
         have_prev <= 1'b0;
      end else if (!in_drain) begin
         have_prev <= 1'b0;
      end else if (item_ok) begin
         if (have_prev && (srt_rdata > prev_item))
            order_err <= 1'b1;
         prev_item <= srt_rdata;
         have_prev <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_sort_batch_ctrl.sv
// tb/tb_sort_batch_ctrl.sv - scoreboard bench for sort_batch_ctrl with a behavioural sorter
module tb_sort_batch_ctrl;
   logic       clk;
   logic       nreset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] srt_data;
   logic       srt_valid;
   logic       srt_flush;
   logic [7:0] srt_rdata;
   logic       srt_rvalid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       busy;
   logic       timeout;
`ifdef SORT_BATCH_ORDER_CHECK_EN
   logic       order_err;
`endif

   sort_batch_ctrl dut (
      .clk        (clk),
      .nreset     (nreset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .srt_data   (srt_data),
      .srt_valid  (srt_valid),
      .srt_flush  (srt_flush),
      .srt_rdata  (srt_rdata),
      .srt_rvalid (srt_rvalid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .busy       (busy),
`ifdef SORT_BATCH_ORDER_CHECK_EN
      .order_err  (order_err),
`endif
      .timeout    (timeout)
   );

   typedef struct {
      int data;
      bit last;
      bit oe;
   } exp_t;

   exp_t exp_q[$];
   int   mdl_q[$];
   int   script_q[$];
   int   mdl_budget = -1;
   int   ins_pos;
   int   vectors = 0;
   int   miscompares = 0;
   int   flush_rise = 0;
   bit   flush_prev = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Ideal sorter: keeps loaded items descending and returns one per flush cycle.
   always @(negedge clk) begin
      srt_rvalid = 1'b0;
      if (srt_valid) begin
         ins_pos = 0;
         while (ins_pos < mdl_q.size() && mdl_q[ins_pos] >= int'(srt_data))
            ins_pos++;
         mdl_q.insert(ins_pos, int'(srt_data));
      end
      if (srt_flush) begin
         if (script_q.size() > 0) begin
            srt_rvalid = 1'b1;
            srt_rdata  = 8'(script_q.pop_front());
         end else if (mdl_q.size() > 0 && mdl_budget != 0) begin
            srt_rvalid = 1'b1;
            srt_rdata  = 8'(mdl_q.pop_front());
            if (mdl_budget > 0)
               mdl_budget--;
         end
      end
   end

   always @(negedge clk) begin
      if (srt_flush && !flush_prev)
         flush_rise++;
      flush_prev = srt_flush;
   end

   // Monitor: every presented output is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL out_unexpected: got data %0d last %0d with empty scoreboard at %0t",
                     out_data, out_last, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data", int'(out_data), e.data);
            chk("out_last", int'(out_last), int'(e.last));
`ifdef SORT_BATCH_ORDER_CHECK_EN
            chk("order_err", int'(order_err), int'(e.oe));
`endif
         end
      end
   end

   task automatic do_reset();
      nreset   = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_srt_valid", int'(srt_valid), 0);
      chk("rst_srt_data", int'(srt_data), 0);
      chk("rst_srt_flush", int'(srt_flush), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_timeout", int'(timeout), 0);
`ifdef SORT_BATCH_ORDER_CHECK_EN
      chk("rst_order_err", int'(order_err), 0);
`endif
      mdl_q.delete();
      script_q.delete();
      exp_q.delete();
      mdl_budget = -1;
      nreset = 1'b1;
   endtask

   task automatic send_batch(input int base, input int n, input bit last_on_end);
      int w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", int'(in_ready), 1);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(base + i);
         in_last  = last_on_end && (i == n - 1);
         @(negedge clk);
         chk("srt_valid", int'(srt_valid), 1);
         chk("srt_data", int'(srt_data), base + i);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_desc(input int hi, input int cnt, input bit with_last);
      for (int k = 0; k < cnt; k++) begin
         exp_t e;
         e.data = hi - k;
         e.last = with_last && (k == cnt - 1);
         e.oe   = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle(input int limit);
      int w = 0;
      while (busy && w < limit) begin
         @(negedge clk);
         w++;
      end
      chk("idle_reached", int'(busy), 0);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      int f0;
      int n;
      int w;
      clk        = 1'b0;
      nreset     = 1'b0;
      in_data    = '0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      srt_rdata  = '0;
      srt_rvalid = 1'b0;

      do_reset();
      @(negedge clk);
      chk("ready_after_rst", int'(in_ready), 1);

      // Full batch 1..22, no in_last: closes on count, drains 22..1.
      f0 = flush_rise;
      expect_desc(22, 22, 1'b1);
      send_batch(1, 22, 1'b0);
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_flush", int'(srt_flush), 1);
      chk("full_busy", int'(busy), 1);
      wait_idle(100);
      chk("full_drain_entries", flush_rise - f0, 1);

      // Early close via in_last on item 5.
      expect_desc(14, 5, 1'b1);
      send_batch(10, 5, 1'b1);
      chk("short_in_ready", int'(in_ready), 0);
      chk("short_flush", int'(srt_flush), 1);
      wait_idle(100);

      // in_last coincides with the 22nd item: one DRAIN entry only.
      f0 = flush_rise;
      expect_desc(121, 22, 1'b1);
      send_batch(100, 22, 1'b1);
      wait_idle(100);
      chk("both_drain_entries", flush_rise - f0, 1);

      // Sorter returns 3 of 5: timeout after 44 drain cycles, no out_last.
      mdl_budget = 3;
      expect_desc(5, 3, 1'b0);
      send_batch(1, 5, 1'b1);
      n = 0;
      w = 0;
      while (!timeout && w < 200) begin
         if (srt_flush)
            n++;
         @(negedge clk);
         w++;
      end
      chk("tmo_set", int'(timeout), 1);
      chk("tmo_drain_cycles", n, 44);
      chk("tmo_gap_busy", int'(busy), 1);
      chk("tmo_gap_flush", int'(srt_flush), 0);
      @(negedge clk);
      @(negedge clk);
      chk("tmo_idle", int'(busy), 0);
      chk("tmo_sticky", int'(timeout), 1);
      chk("tmo_scoreboard_empty", exp_q.size(), 0);
      mdl_q.delete();
      mdl_budget = -1;

      // Reset in DRAIN after two outputs, then a fresh 4-item batch.
      do_reset();
      expect_desc(6, 2, 1'b0);
      send_batch(1, 6, 1'b1);
      n = 0;
      w = 0;
      while (n < 2 && w < 100) begin
         @(negedge clk);
         w++;
         if (out_valid)
            n++;
      end
      chk("mid_outputs_seen", n, 2);
      do_reset();
      expect_desc(43, 4, 1'b1);
      send_batch(40, 4, 1'b1);
      wait_idle(100);

`ifdef SORT_BATCH_ORDER_CHECK_EN
      // Sorter emits 9,7,8: order_err rises with the 8.
      begin
         exp_t e;
         script_q = '{9, 7, 8};
         e.data = 9; e.last = 1'b0; e.oe = 1'b0; exp_q.push_back(e);
         e.data = 7; e.last = 1'b0; e.oe = 1'b0; exp_q.push_back(e);
         e.data = 8; e.last = 1'b1; e.oe = 1'b1; exp_q.push_back(e);
      end
      send_batch(1, 3, 1'b1);
      chk("order_pre", int'(order_err), 0);
      wait_idle(100);
      chk("order_sticky", int'(order_err), 1);
      mdl_q.delete();
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
      $fatal(1, "watchdog expired");
   end
endmodule
